// File: rtl/pjdl_link_scheduler_if.sv
// Control bundle between the PJDL link scheduler and its frame source / sender / receiver.
// Signal suffixes are relative to the scheduler (the master side).
interface pjdl_link_scheduler_if;
  logic        tx_req_i;
  logic        tx_ack_req_i;
  logic        pjon_i;
  logic        rx_busy_i;
  logic        tx_done_i;
  logic        ack_valid_i;
  logic [7:0]  ack_byte_i;
  logic [15:0] cfg_window_i;
  logic [15:0] cfg_backoff_i;
  logic [19:0] cfg_ack_timeout_i;
  logic        tx_start_o;
  logic        rx_enable_o;
  logic        ack_rx_start_o;
  logic        busy_o;
  logic        result_valid_o;
  logic        result_ok_o;
  logic [3:0]  attempt_o;

  modport master (
    input  tx_req_i, tx_ack_req_i, pjon_i, rx_busy_i, tx_done_i, ack_valid_i, ack_byte_i,
    input  cfg_window_i, cfg_backoff_i, cfg_ack_timeout_i,
    output tx_start_o, rx_enable_o, ack_rx_start_o, busy_o, result_valid_o, result_ok_o,
    output attempt_o
  );

  modport slave (
    output tx_req_i, tx_ack_req_i, pjon_i, rx_busy_i, tx_done_i, ack_valid_i, ack_byte_i,
    output cfg_window_i, cfg_backoff_i, cfg_ack_timeout_i,
    input  tx_start_o, rx_enable_o, ack_rx_start_o, busy_o, result_valid_o, result_ok_o,
    input  attempt_o
  );
endinterface

// File: rtl/pjdl_link_scheduler.sv
// PJDL link scheduler: line sensing, backoff, send, ACK wait with timeout and bounded retries.
// Define PJDL_SCHED_RANDOM_BACKOFF_EN to add an LFSR-based random term to the backoff delay.
module pjdl_link_scheduler #(
  parameter int unsigned MaxAttempts = 3,
  parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
  input logic                   clk_i,
  input logic                   rst_i,
  pjdl_link_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StSense, StBackoff, StTransmit, StAckWait, StReport
  } state_e;

  localparam logic [7:0] AckByte = 8'h06;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  attempt_q, attempt_d;
  logic        ack_flag_q, ack_flag_d;
  logic        ok_q, ok_d;

  logic        tx_start_q, rx_enable_q, ack_rx_start_q, busy_q, result_valid_q;

  logic [15:0] win_eff;
  logic [16:0] delay;
  logic [19:0] backoff_load;
  logic        clean;
  logic        ack_good;
  logic        attempt_fail;

`ifdef PJDL_SCHED_RANDOM_BACKOFF_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11; free-running in every state.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign delay = {1'b0, bus.cfg_backoff_i} + {9'b0, lfsr_q[7:0]};
`else
  logic unused_seed;
  assign unused_seed = ^LfsrSeed;
  assign delay       = {1'b0, bus.cfg_backoff_i};
`endif

  assign win_eff      = (bus.cfg_window_i == 16'd0) ? 16'd1 : bus.cfg_window_i;
  assign backoff_load = (delay == 17'd0) ? 20'd1 : {3'b0, delay};
  assign clean        = !bus.pjon_i && !bus.rx_busy_i;
  assign ack_good     = bus.ack_valid_i && (bus.ack_byte_i == AckByte);
  // A non-ACK byte or an expired timer fails the attempt; a good ACK takes precedence.
  assign attempt_fail = bus.ack_valid_i || (cnt_q == bus.cfg_ack_timeout_i);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    attempt_d  = attempt_q;
    ack_flag_d = ack_flag_q;
    ok_d       = ok_q;
    unique case (state_q)
      StIdle: begin
        if (bus.tx_req_i) begin
          ack_flag_d = bus.tx_ack_req_i;
          attempt_d  = 4'd0;
          cnt_d      = 20'd0;
          state_d    = StSense;
        end
      end
      StSense: begin
        if (!clean) begin
          cnt_d   = backoff_load;
          state_d = StBackoff;
        end else if (cnt_q + 20'd1 >= {4'b0, win_eff}) begin
          cnt_d     = 20'd0;
          attempt_d = attempt_q + 4'd1;
          state_d   = StTransmit;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      StBackoff: begin
        if (cnt_q <= 20'd1) begin
          cnt_d   = 20'd0;
          state_d = StSense;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      StTransmit: begin
        if (bus.tx_done_i) begin
          cnt_d = 20'd0;
          if (ack_flag_q) begin
            state_d = StAckWait;
          end else begin
            ok_d    = 1'b1;
            state_d = StReport;
          end
        end
      end
      StAckWait: begin
        if (ack_good) begin
          ok_d    = 1'b1;
          state_d = StReport;
        end else if (attempt_fail) begin
          if (attempt_q < 4'(MaxAttempts)) begin
            cnt_d   = backoff_load;
            state_d = StBackoff;
          end else begin
            ok_d    = 1'b0;
            state_d = StReport;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so each pulse lines up with its state's first cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      cnt_q          <= 20'd0;
      attempt_q      <= 4'd0;
      ack_flag_q     <= 1'b0;
      ok_q           <= 1'b0;
      tx_start_q     <= 1'b0;
      rx_enable_q    <= 1'b1;
      ack_rx_start_q <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      attempt_q      <= attempt_d;
      ack_flag_q     <= ack_flag_d;
      ok_q           <= ok_d;
      tx_start_q     <= (state_d == StTransmit) && (state_q != StTransmit);
      rx_enable_q    <= (state_d != StTransmit);
      ack_rx_start_q <= (state_d == StAckWait) && (state_q != StAckWait);
      busy_q         <= (state_d != StIdle);
      result_valid_q <= (state_d == StReport);
    end
  end

  assign bus.tx_start_o     = tx_start_q;
  assign bus.rx_enable_o    = rx_enable_q;
  assign bus.ack_rx_start_o = ack_rx_start_q;
  assign bus.busy_o         = busy_q;
  assign bus.result_valid_o = result_valid_q;
  assign bus.result_ok_o    = ok_q;
  assign bus.attempt_o      = attempt_q;

endmodule

// File: doc/pjdl_link_scheduler.md
# pjdl_link_scheduler

Sequences one PJDL frame transmission on the shared single-wire medium: senses the line for silence, applies pseudo-random backoff on contention, starts the PJDL sender, and, when an acknowledgement is requested, hands the line to the PJDL receiver and evaluates the returned ACK/NAK byte with timeout and bounded retries. Sits between the Layer-3 frame source and the `pjdl_send`/`pjdl_receive` pair and owns their enable/start controls.

## Interface
- `MaxAttempts`, default 3: total transmission attempts per request, legal range 1..15.
- `LfsrSeed`, default 16'hACE1: LFSR reset value. Must be non-zero.
- `clk_i` input 1: system clock.
- `rst_i` input 1: asynchronous, active-high reset. This is already decided.
- `tx_req_i` input 1: request one frame. Sampled only in Idle.
- `tx_ack_req_i` input 1: frame expects an ACK. Sampled with `tx_req_i`.
- `pjon_i` input 1: synchronised line level.
- `rx_busy_i` input 1: receiver `receiving_in_progress_o`.
- `tx_done_i` input 1: one-cycle pulse from the sender at frame end.
- `ack_valid_i` input 1: receiver delivered a byte (AXIS `tvalid && tready`).
- `ack_byte_i` input 8: that byte.
- `cfg_window_i` input 16: silence window in cycles. A value of 0 is treated as 1.
- `cfg_backoff_i` input 16: backoff base in cycles.
- `cfg_ack_timeout_i` input 20: ACK wait limit in cycles.
- `tx_start_o` output 1: one-cycle start pulse to the sender.
- `rx_enable_o` output 1: receiver `enable_i`.
- `ack_rx_start_o` output 1: one-cycle pulse to receiver `start_ack_receiving_i`.
- `busy_o` output 1: request in progress.
- `result_valid_o` output 1: one-cycle completion pulse.
- `result_ok_o` output 1: completion status. Valid with `result_valid_o`, held until the next result.
- `attempt_o` output 4: attempts made for the current or last request.

## Operation
- States: Idle, Sense, Backoff, Transmit, AckWait, Report.
- **Idle**
  - `tx_req_i=1` latches `tx_ack_req_i`, clears the attempt count, and goes to Sense.
- **Sense**
  - A clean cycle is one where `pjon_i=0 && rx_busy_i=0`. A clean cycle increments the silence counter.
  - When the counter reaches `max(cfg_window_i,1)`, go to Transmit and increment the attempt count.
  - Any non-clean cycle goes to Backoff. Backoff does not consume an attempt.
- **Backoff**
  - Delay is `cfg_backoff_i + lfsr[7:0]`, a 17-bit unsigned sum. It is loaded on entry.
  - Stay in Backoff for `max(delay,1)` cycles, then go to Sense with the silence counter cleared.
- **Transmit**
  - `tx_start_o` is high on the first Transmit cycle only.
  - Wait for `tx_done_i`. If the latched ack flag is 0, go to Report with ok=1. If it is 1, go to AckWait.
- **AckWait**
  - `ack_rx_start_o` is high on the first AckWait cycle only. The timeout counter starts at 0.
  - `ack_valid_i` with byte 8'h06 goes to Report with ok=1.
  - Any other byte (including NAK 8'h15), or the counter reaching `cfg_ack_timeout_i`, is a failed attempt:
    - if `attempt < MaxAttempts`, go to Backoff;
    - otherwise go to Report with ok=0.
- **Report**
  - `result_valid_o` is high for this single cycle. Return to Idle.
- Output encoding:
  - `rx_enable_o` is 0 only in Transmit.
  - `busy_o` is 1 in every state except Idle.
- Precedence and ignored inputs:
  - In AckWait, `ack_valid_i` wins over a simultaneous timeout.
  - `tx_done_i` outside Transmit is ignored.
  - `ack_valid_i` outside AckWait is ignored.
  - `tx_req_i` while busy is ignored.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle regardless of state.

## Timing
- All outputs are registered.
- Reset values: state Idle, `rx_enable_o=1`, every other output 0, LFSR = `LfsrSeed`.
- Reset mid-operation aborts immediately. No `result_valid_o` is produced and no start pulses follow.
- Latency:
  - `tx_req_i` sampled in cycle N puts the block in Sense at N+1.
  - With a continuously clean line, `tx_start_o` is high at cycle N+1+W, where W = `max(cfg_window_i,1)`.
- `tx_done_i` at cycle M:
  - with ack flag 0, `result_valid_o` is high at M+1;
  - with ack flag 1, `ack_rx_start_o` is high at M+1.
- Timeout fires on the cycle the counter equals `cfg_ack_timeout_i`. That is `cfg_ack_timeout_i+1` cycles after AckWait entry. The state changes on the next edge.

## Configuration
- `PJDL_SCHED_RANDOM_BACKOFF_EN`
  - Defined: the LFSR is present and the backoff delay is `cfg_backoff_i + lfsr[7:0]`.
  - Undefined: the LFSR is removed, the `LfsrSeed` parameter is unused, and the delay is exactly `max(cfg_backoff_i,1)`, so timing is fully deterministic.

## Test plan
- **No-ack send.** Inputs: window=4, line idle, `tx_req_i` at cycle 10 with ack=0. Required: `tx_start_o` at cycle 15; `tx_done_i` at cycle 40 gives `result_valid_o`=1 and `result_ok_o`=1 at cycle 41, with `attempt_o`=1.
- **Contention.** Input: `pjon_i`=1 during Sense cycle 2. Required: enter Backoff. With the macro undefined and base=20, Backoff lasts exactly 20 cycles, then Sense restarts from 0. `attempt_o` stays 0.
- **ACK success.** Input: ack=1, byte 8'h06 arrives 30 cycles after `ack_rx_start_o`, with timeout=1000. Required: ok=1 and `attempt_o`=1. `rx_enable_o` is 0 exactly during Transmit.
- **Exhausted retries.** Inputs: MaxAttempts=3, each attempt answered with 8'h15. Required: three `tx_start_o` pulses, then `result_ok_o`=0 with `attempt_o`=3.
- **Timeout and precedence.** Input: timeout=50 with no byte. Required: retry to Backoff after 51 cycles. Input: `ack_valid_i` with 8'h06 on the timeout cycle. Required: ok=1.
- **Reset abort.** Input: `rst_i` asserted in AckWait. Required: outputs return to reset values asynchronously and no `result_valid_o` occurs.
